// File: rtl/time_counter_pkg.sv
// time_counter_pkg: FSM state codes and active-low 7-segment patterns {g,f,e,d,c,b,a}.
package time_counter_pkg;
    localparam logic [2:0] S0 = 3'b000;
    localparam logic [2:0] S1 = 3'b001;
    localparam logic [2:0] S2 = 3'b010;
    localparam logic [2:0] S3 = 3'b011;
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
endpackage

// File: rtl/seg7_decoder.sv
// seg7_decoder: BCD digit to active-low 7-segment pattern, blank above 9.
module seg7_decoder
    import time_counter_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);
    always_comb begin
        case (bcd_i)
            4'd0: seg_o = SEG_0;
            4'd1: seg_o = SEG_1;
            4'd2: seg_o = SEG_2;
            4'd3: seg_o = SEG_3;
            4'd4: seg_o = SEG_4;
            4'd5: seg_o = SEG_5;
            4'd6: seg_o = SEG_6;
            4'd7: seg_o = SEG_7;
            4'd8: seg_o = SEG_8;
            4'd9: seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end
endmodule

// File: rtl/time_counter_with_display.sv
// time_counter_with_display: MM:SS up/down stopwatch with switch-driven FSM,
// 1 Hz tick divider, blinking status LED and four 7-segment digits.
module time_counter_with_display
    import time_counter_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       switch0,
    input  logic       switch1,
    input  logic       switch2,
    output logic [6:0] seg1,
    output logic [6:0] seg2,
    output logic [6:0] seg3,
    output logic [6:0] seg4,
    output logic [2:0] state,
    output logic       led
);
    localparam int DW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    logic [2:0]    state_q, state_d;
    logic [DW-1:0] div_q, div_d, half_q, half_d;
    logic          blink_q, blink_d;
    logic [5:0]    second_count, minute_count, sec_d, min_d;
    logic          run, clr, tick, half_wrap;
    always_comb begin
        state_d   = {1'b0, switch1, switch0};
        run       = state_q == S1;
        clr       = state_q == S3;
        tick      = run && div_q == DW'(TICK_DIV - 1);
        div_d     = clr ? '0 : !run ? div_q : tick ? '0 : div_q + 1'b1;
        // blink phase counter is separate from the divider so it restarts on every S1 entry
        half_wrap = half_q == DW'(TICK_DIV / 2 - 1);
        half_d    = (!run || half_wrap) ? '0 : half_q + 1'b1;
        blink_d   = run && (blink_q ^ half_wrap);
        sec_d     = second_count;
        min_d     = minute_count;
        if (clr) begin
            sec_d = '0;
            min_d = '0;
        end else if (tick && !switch2) begin
            sec_d = (second_count == 6'd59) ? '0 : second_count + 1'b1;
            min_d = (second_count != 6'd59) ? minute_count : (minute_count == 6'd59) ? '0 : minute_count + 1'b1;
        end else if (tick) begin
            sec_d = (second_count == 6'd0) ? 6'd59 : second_count - 1'b1;
            min_d = (second_count != 6'd0) ? minute_count : (minute_count == 6'd0) ? 6'd59 : minute_count - 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S0;
            div_q        <= '0;
            half_q       <= '0;
            blink_q      <= 1'b0;
            second_count <= '0;
            minute_count <= '0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            half_q       <= half_d;
            blink_q      <= blink_d;
            second_count <= sec_d;
            minute_count <= min_d;
        end
    end
    assign state = state_q;
    assign led   = (state_q == S2) || (run && blink_q);
    seg7_decoder u_seg1 (.bcd_i(4'(minute_count / 6'd10)), .seg_o(seg1));
    seg7_decoder u_seg2 (.bcd_i(4'(minute_count % 6'd10)), .seg_o(seg2));
    seg7_decoder u_seg3 (.bcd_i(4'(second_count / 6'd10)), .seg_o(seg3));
    seg7_decoder u_seg4 (.bcd_i(4'(second_count % 6'd10)), .seg_o(seg4));
endmodule

// File: tb/tb_time_counter_with_display.sv
// tb_time_counter_with_display: directed and random switch sequences checked against
// a total-seconds stopwatch model.
module tb_time_counter_with_display;
    localparam int TD = 4;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       switch0 = 1'b0, switch1 = 1'b0, switch2 = 1'b0;
    logic [6:0] seg1, seg2, seg3, seg4;
    logic [2:0] state;
    logic       led;
    int n_cmp = 0, n_err = 0;
    int m_st = 0, m_t = 0, m_runtot = 0, m_runcyc = 0;

    time_counter_with_display #(.TICK_DIV(TD)) dut (
        .clk(clk), .rst(rst), .switch0(switch0), .switch1(switch1), .switch2(switch2),
        .seg1(seg1), .seg2(seg2), .seg3(seg3), .seg4(seg4), .state(state), .led(led)
    );

    always #10 clk = ~clk;

    function automatic int seg_of(int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic check_all();
        int mm, ss;
        mm = m_t / 60;
        ss = m_t % 60;
        check("state", int'(state), m_st);
        check("second_count", int'(dut.second_count), ss);
        check("minute_count", int'(dut.minute_count), mm);
        check("seg1", int'(seg1), seg_of(mm / 10));
        check("seg2", int'(seg2), seg_of(mm % 10));
        check("seg3", int'(seg3), seg_of(ss / 10));
        check("seg4", int'(seg4), seg_of(ss % 10));
        check("led", int'(led), m_st == 2 ? 1 : m_st == 1 ? (m_runcyc / (TD / 2)) % 2 : 0);
    endtask

    // Model advances on the same edge as the DUT, outputs compared at the falling edge.
    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            if (rst) begin
                m_st = 0; m_t = 0; m_runtot = 0; m_runcyc = 0;
            end else begin
                if (m_st == 1) begin
                    if (m_runtot % TD == TD - 1) m_t = switch2 ? (m_t + 3599) % 3600 : (m_t + 1) % 3600;
                    m_runtot++;
                end else if (m_st == 3) begin
                    m_t = 0;
                    m_runtot = 0;
                end
                m_runcyc = (m_st == 1) ? m_runcyc + 1 : 0;
                m_st = (switch0 && switch1) ? 3 : switch0 ? 1 : switch1 ? 2 : 0;
            end
            @(negedge clk);
            check_all();
        end
    endtask

    task automatic set_sw(input logic s0, input logic s1, input logic s2);
        switch0 = s0;
        switch1 = s1;
        switch2 = s2;
    endtask

    initial begin
        step(5);
        rst = 1'b0;
        step(2);
        check("idle_seg4", int'(seg4), 7'b1000000);
        set_sw(1, 0, 0);
        step(1);
        check("run_state", int'(state), 1);
        step(240);
        check("min_after_60", int'(dut.minute_count), 1);
        check("sec_after_60", int'(dut.second_count), 0);
        set_sw(0, 1, 0);
        step(100);
        check("pause_led", int'(led), 1);
        check("pause_min", int'(dut.minute_count), 1);
        set_sw(1, 1, 0);
        step(2);
        check("clear_state", int'(state), 3);
        check("clear_sec", int'(dut.second_count), 0);
        check("clear_led", int'(led), 0);
        set_sw(1, 0, 0);
        step(41);
        check("resume_sec", int'(dut.second_count), 10);
        set_sw(1, 1, 0);
        step(2);
        set_sw(1, 0, 1);
        step(5);
        check("wrap_dn_seg1", int'(seg1), 7'b0010010);
        check("wrap_dn_seg2", int'(seg2), 7'b0010000);
        check("wrap_dn_seg3", int'(seg3), 7'b0010010);
        check("wrap_dn_seg4", int'(seg4), 7'b0010000);
        set_sw(1, 0, 0);
        step(4);
        check("wrap_up_min", int'(dut.minute_count), 0);
        check("wrap_up_sec", int'(dut.second_count), 0);
        for (int c = 0; c < 1500;) begin
            int sel, len;
            sel = $urandom_range(0, 7);
            len = $urandom_range(1, 40);
            rst = ($urandom_range(0, 19) == 0);
            set_sw(sel <= 3 || sel == 6, sel == 5 || sel == 6, 1'($urandom_range(0, 1)));
            step(rst ? 1 : len);
            c += rst ? 1 : len;
        end
        rst = 1'b0;
        set_sw(1, 0, 0);
        step(30);
        rst = 1'b1;
        step(1);
        check("rst_state", int'(state), 0);
        check("rst_sec", int'(dut.second_count), 0);
        check("rst_led", int'(led), 0);
        rst = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
